// File: rtl/fir_sequencer.sv
// fir_sequencer
// Control and datapath for a serial 1-bit-sample FIR filter. Each accepted
// sample is pushed into an external history shift register. The resulting tap
// vector is snapshotted, and NTAPS coefficients are walked from a ROM with
// one cycle of read latency. Each coefficient is added when its tap bit is 1
// and subtracted when it is 0.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   sample_valid one-cycle strobe, new sample on sample_in
//   sample_in    new sample bit x[n]
//   sr_ready     shift strobe to the history shift register
//   sr_x         sample bit presented to the history shift register
//   sr_taps      tap vector from the shift register, bit k = x[n-k]
//   coef_addr    coefficient ROM address
//   coef_data    signed coefficient, valid one cycle after coef_addr
//   y            signed filter result, held between strobes
//   y_valid      one-cycle strobe, y holds a new result
//   busy         high whenever the sequencer is not idle
//   overrun      sticky, a sample arrived while busy and was dropped
//   overrun_clr  clears overrun (a simultaneous new overrun wins)
//
// state | meaning
// IDLE  | waiting for sample_valid
// SHIFT | sr_ready high, shift register takes sr_x
// FETCH | snapshot taps, first ROM word in flight
// ACC   | one signed term per cycle, NTAPS cycles
// DONE  | y_valid high, y holds the new result
module fir_sequencer #(
   parameter int NTAPS = 51,
   parameter int CW    = 12,
   parameter int AW    = 18
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_valid,
   input  logic                 sample_in,
   output logic                 sr_ready,
   output logic                 sr_x,
   input  logic [NTAPS-1:0]     sr_taps,
   output logic [5:0]           coef_addr,
   input  logic signed [CW-1:0] coef_data,
   output logic signed [AW-1:0] y,
   output logic                 y_valid,
   output logic                 busy,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      FETCH = 3'd2,
      ACC   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [IW-1:0]        idx;
   logic [NTAPS-1:0]     tap_snap;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_nxt;
   logic signed [AW-1:0] coef_ext;
   logic                 accept;
   logic                 drop;
   logic                 last_tap;

   assign accept   = (state == IDLE) && sample_valid;
   assign drop     = (state != IDLE) && sample_valid;
   assign last_tap = (idx == LAST_IDX);
   assign busy     = (state != IDLE);
   assign coef_ext = {{(AW-CW){coef_data[CW-1]}}, coef_data};

   always_comb begin
      acc_nxt = acc;
      if (tap_snap[idx]) acc_nxt = acc + coef_ext;
      else               acc_nxt = acc - coef_ext;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sample_valid) state_nxt = SHIFT;
         SHIFT:   state_nxt = FETCH;
         FETCH:   state_nxt = ACC;
         ACC:     if (last_tap) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // coef_addr is cleared on accept so it reads 0 through SHIFT and FETCH.
   // The ROM word for address 0 is then on coef_data in the first ACC cycle,
   // while address 1 is already being fetched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_ready  <= 1'b0;
         sr_x      <= 1'b0;
         coef_addr <= '0;
         idx       <= '0;
         tap_snap  <= '0;
         acc       <= '0;
         y         <= '0;
         y_valid   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sr_ready <= accept;
         y_valid  <= 1'b0;
         if (accept) begin
            sr_x      <= sample_in;
            acc       <= '0;
            coef_addr <= '0;
         end
         case (state)
            FETCH: begin
               tap_snap  <= sr_taps;
               coef_addr <= 6'd1;
               idx       <= '0;
            end
            ACC: begin
               acc       <= acc_nxt;
               idx       <= idx + IW'(1);
               coef_addr <= coef_addr + 6'd1;
               // The final term goes straight into y, so y and y_valid
               // appear together in DONE.
               if (last_tap) begin
                  y       <= acc_nxt;
                  y_valid <= 1'b1;
               end
            end
            default: ;
         endcase
         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_sequencer.sv
// Testbench for fir_sequencer.
// Models the external history shift register and the coefficient ROM. A
// reference model computes each expected result directly as
// sum(+/-coef[k]) over the bench's own copy of the sample history.
// Expected results are queued together with their due cycle, and a monitor
// pops and compares them whenever y_valid is seen.
module tb_fir_sequencer;

   localparam int NTAPS = 51;
   localparam int CW    = 12;
   localparam int AW    = 18;

   logic                 clk;
   logic                 reset;
   logic                 sample_valid;
   logic                 sample_in;
   logic                 sr_ready;
   logic                 sr_x;
   logic [NTAPS-1:0]     sr_taps;
   logic [5:0]           coef_addr;
   logic signed [CW-1:0] coef_data;
   logic signed [AW-1:0] y;
   logic                 y_valid;
   logic                 busy;
   logic                 overrun;
   logic                 overrun_clr;

   fir_sequencer #(.NTAPS(NTAPS), .CW(CW), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .sr_ready     (sr_ready),
      .sr_x         (sr_x),
      .sr_taps      (sr_taps),
      .coef_addr    (coef_addr),
      .coef_data    (coef_data),
      .y            (y),
      .y_valid      (y_valid),
      .busy         (busy),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // external shift register and ROM models
   logic [NTAPS-1:0]     sr = '0;
   logic                 sr_load = 1'b0;
   logic [NTAPS-1:0]     sr_load_val = '0;
   logic signed [CW-1:0] rom [64];

   assign sr_taps = sr;

   always @(posedge clk) begin
      if (sr_load)       sr <= sr_load_val;
      else if (sr_ready) sr <= {sr[NTAPS-2:0], sr_x};
   end

   always @(posedge clk) coef_data <= rom[coef_addr];

   // reference model state
   typedef struct {
      int y;
      int cyc;
   } exp_t;

   exp_t             q[$];
   logic [NTAPS-1:0] hist     = '0;
   int               last_acc = -1000;
   bit               ovr_exp  = 1'b0;
   bit               x_exp    = 1'b0;
   int               y_hold   = 0;
   int               n_chk    = 0;
   int               n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
      end
   endtask

   function automatic int model_y(input logic [NTAPS-1:0] h);
      int s = 0;
      for (int k = 0; k < NTAPS; k++) begin
         if (h[k]) s = s + int'(rom[k]);
         else      s = s - int'(rom[k]);
      end
      return s;
   endfunction

   function automatic logic [NTAPS-1:0] rand_taps();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[NTAPS-1:0];
   endfunction

   task automatic rand_rom();
      logic [31:0] t;
      for (int k = 0; k < 64; k++) begin
         t = $urandom();
         rom[k] = t[CW-1:0];
      end
   endtask

   task automatic fill_rom(input int v);
      logic [31:0] t;
      t = v;
      for (int k = 0; k < 64; k++) rom[k] = t[CW-1:0];
   endtask

   // One clock of stimulus. Called just after a falling edge. The sample is
   // accepted only if more than 54 edges have passed since the last accepted
   // one: busy covers 54 cycles, and only then is the sequencer idle again.
   task automatic step(input bit sv, input bit x, input bit clr);
      int   e;
      bit   ok;
      exp_t ent;
      e  = cyc + 1;
      ok = sv && (e > last_acc + 54);
      sample_valid = sv;
      sample_in    = x;
      overrun_clr  = clr;
      if (ok) begin
         hist    = {hist[NTAPS-2:0], x};
         ent.y   = model_y(hist);
         ent.cyc = e + 53;
         q.push_back(ent);
         last_acc = e;
         x_exp    = x;
      end
      if (sv && !ok) ovr_exp = 1'b1;
      else if (clr)  ovr_exp = 1'b0;
      @(negedge clk);
      sample_valid = 1'b0;
      sample_in    = 1'b0;
      overrun_clr  = 1'b0;
      chk("overrun", int'(overrun), int'(ovr_exp));
      chk("sr_ready", int'(sr_ready), int'(cyc == last_acc));
      chk("busy", int'(busy), int'(cyc >= last_acc && cyc <= last_acc + 53));
      chk("sr_x", int'(sr_x), int'(x_exp));
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic preload(input logic [NTAPS-1:0] v);
      sr_load     = 1'b1;
      sr_load_val = v;
      hist        = v;
      step(1'b0, 1'b0, 1'b0);
      sr_load     = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_y"}, int'(y), 0);
      chk({tag, "_y_valid"}, int'(y_valid), 0);
      chk({tag, "_sr_ready"}, int'(sr_ready), 0);
      chk({tag, "_sr_x"}, int'(sr_x), 0);
      chk({tag, "_coef_addr"}, int'(coef_addr), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
   endtask

   // Assert reset away from the falling edge so the monitor never races it.
   task automatic do_reset();
      #2 reset = 1'b1;
      #1 check_reset_outputs("reset_mid");
      q.delete();
      y_hold   = 0;
      last_acc = -1000;
      ovr_exp  = 1'b0;
      x_exp    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (y_valid) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL y_valid_unexpected at cycle %0d: got y_valid=1 with y=%0d, expected none",
                     cyc, int'(y));
         end else begin
            e = q.pop_front();
            chk("y_value", int'(y), e.y);
            chk("y_latency", cyc, e.cyc);
            y_hold = e.y;
         end
      end else begin
         chk("y_hold", int'(y), y_hold);
      end
   end

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_in    = 1'b0;
      overrun_clr  = 1'b0;
      fill_rom(0);
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset_init");
      #2 reset = 1'b0;
      @(negedge clk);

      // coef[k] = k+1, only the new sample bit set
      for (int k = 0; k < 64; k++) rom[k] = CW'(k + 1);
      preload('0);
      step(1'b1, 1'b1, 1'b0);
      idle(60);
      chk("y_coef_ramp", int'(y), -1324);

      // extremes
      fill_rom(2047);
      preload('1);
      step(1'b1, 1'b1, 1'b0);
      idle(56);
      chk("y_max_pos", int'(y), 104397);
      fill_rom(-2048);
      preload('0);
      step(1'b1, 1'b0, 1'b0);
      idle(56);
      chk("y_max_neg", int'(y), 104448);

      // overrun: drop at +10, clear and new drop together, then a plain clear
      rand_rom();
      preload(rand_taps());
      step(1'b1, 1'b1, 1'b0);
      idle(9);
      step(1'b1, 1'b0, 1'b0);
      chk("overrun_set", int'(overrun), 1);
      idle(5);
      step(1'b1, 1'b1, 1'b1);
      chk("overrun_set_wins", int'(overrun), 1);
      idle(45);
      step(1'b0, 1'b0, 1'b1);
      chk("overrun_clr", int'(overrun), 0);

      // tap changes after the snapshot must not disturb the result
      step(1'b1, 1'b0, 1'b0);
      idle(20);
      preload(rand_taps());
      idle(40);

      // back-to-back: sample during DONE dropped, next cycle accepted
      step(1'b1, 1'b1, 1'b0);
      idle(53);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      idle(60);
      step(1'b0, 1'b0, 1'b1);

      // reset mid-ACC, then a normal sample
      step(1'b1, 1'b1, 1'b0);
      idle(29);
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(60);

      // randomized traffic
      rand_rom();
      preload(rand_taps());
      for (int i = 0; i < 800; i++) begin
         step(($urandom() % 16) == 0, 1'($urandom()), ($urandom() % 8) == 0);
      end
      idle(60);

      chk("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 51, number of taps in the history shift register.
REQ-002 SHALL have parameter CW, default 12, signed coefficient width.
REQ-003 SHALL have parameter AW, default 18, signed accumulator and output width (CW+6).
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe; new 1-bit sample present on sample_in.
REQ-007 SHALL have port sample_in  input  1  new sample bit x[n].
REQ-008 SHALL have port sr_ready  output  1  shift strobe to the history shift register (its ready_in).
REQ-009 SHALL have port sr_x  output  1  sample bit to the shift register (its x_n).
REQ-010 SHALL have port sr_taps  input  NTAPS  updated tap vector from the shift register (its shiftreg_new); bit k is x[n-k].
REQ-011 SHALL have port coef_addr  output  6  coefficient ROM address.
REQ-012 SHALL have port coef_data  input  CW  signed coefficient; valid one cycle after coef_addr.
REQ-013 SHALL have port y  output  AW  signed filter result.
REQ-014 SHALL have port y_valid  output  1  one-cycle strobe; y holds the new result.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port overrun  output  1  sticky flag; a sample was dropped.
REQ-017 SHALL have port overrun_clr  input  1  clears overrun.

Function
REQ-018 SHALL implement the states IDLE, SHIFT, FETCH, ACC and DONE.
REQ-019 IDLE: when sample_valid=1, SHALL latch sample_in into sr_x, clear acc and go to SHIFT; otherwise SHALL stay in IDLE.
REQ-020 SHIFT: SHALL drive sr_ready=1 for exactly one cycle, drive coef_addr=0 and go to FETCH.
REQ-021 FETCH: SHALL snapshot sr_taps into an internal tap register, set coef_addr=1, set tap index=0 and go to ACC.
REQ-022 ACC: each cycle SHALL update acc as acc + sext(coef_data) if snapshot bit[idx]=1, else acc - sext(coef_data), then increment idx and coef_addr.
REQ-023 ACC: coef_data used at idx k SHALL be the ROM word for address k (one-cycle ROM latency, prefetched).
REQ-024 ACC: after the term for idx=NTAPS-1, SHALL go to DONE; ACC lasts exactly NTAPS cycles.
REQ-025 ACC: coef_addr values at or beyond NTAPS SHALL be don't-care and SHALL never be accumulated.
REQ-026 DONE: SHALL register y<=acc, pulse y_valid=1 for one cycle and return to IDLE.
REQ-027 Latency: sample_valid sampled at edge 0 SHALL give sr_ready high in cycle 1 and y_valid high in cycle NTAPS+3 (cycle 54 for the default).
REQ-028 y SHALL hold its value between y_valid strobes.
REQ-029 The accumulator SHALL be AW bits signed with no saturation; AW covers NTAPS*2^(CW-1) without overflow.
REQ-030 sample_valid seen in any state other than IDLE SHALL drop the sample, leave sr_x unchanged, and set overrun=1.
REQ-031 A sample arriving in the same cycle as DONE SHALL count as an overrun.
REQ-032 overrun_clr=1 SHALL clear overrun; if a new overrun occurs in the same cycle, set SHALL win.
REQ-033 sr_taps changing after FETCH SHALL not affect the result in progress.

Reset
REQ-034 reset=1 SHALL immediately force state=IDLE and set y, y_valid, sr_ready, sr_x, coef_addr, acc, idx, tap snapshot, busy and overrun to 0.
REQ-035 Reset during any state SHALL abort the computation, produce no y_valid, and the first sample_valid after release SHALL be processed normally.

Verification
REQ-036 Latency: single sample_valid at edge 0 -> sr_ready=1 only in cycle 1; y_valid=1 only in cycle 54; busy=1 in cycles 1-54.
REQ-037 Arithmetic: coef[k]=k+1, sr_taps model = only bit0 set -> y=1-1325=-1324.
REQ-038 Extremes: coef=+2047 with all taps 1 -> y=104397; coef=-2048 with all taps 0 -> y=104448; no wrap.
REQ-039 Overrun: second sample_valid in cycle 10 -> overrun=1, no second sr_ready, first y unchanged; overrun_clr -> 0; clr and new overrun in the same cycle -> remains 1.
REQ-040 Back-to-back: sample_valid in cycle 55 -> accepted, second y_valid in cycle 109; sample_valid in cycle 54 (DONE) -> dropped, overrun=1.
REQ-041 Reset in cycle 30 (mid-ACC) -> all outputs 0 at once, no y_valid; next sample gives the correct result 54 cycles later.
